// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the BCD countdown timer.
//   state_t     : FSM state encoding (IDLE/RUN/PAUSED/DONE)
//   bcd2_t      : two-digit BCD value {tens, ones}
//   MAX_TENS    : largest legal tens digit (5)
//   MAX_ONES    : largest legal ones digit (9)
//   clamp_digit : saturate a BCD digit to a limit
//   bcd_dec     : saturating two-digit BCD decrement (never below 00)
//   bcd_is_zero : true when both digits are 0
// -----------------------------------------------------------------------------
package timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
   } bcd2_t;

   localparam logic [3:0] MAX_TENS = 4'd5;
   localparam logic [3:0] MAX_ONES = 4'd9;

   function automatic logic [3:0] clamp_digit(input logic [3:0] d,
                                              input logic [3:0] lim);
      return (d > lim) ? lim : d;
   endfunction

   function automatic logic bcd_is_zero(input bcd2_t v);
      return (v.tens == 4'd0) && (v.ones == 4'd0);
   endfunction

   // Borrow from tens when ones is 0; at 00 the value saturates so the
   // count can never wrap around to 59.
   function automatic bcd2_t bcd_dec(input bcd2_t v);
      bcd2_t r;
      r = v;
      if (v.ones != 4'd0) begin
         r.ones = v.ones - 4'd1;
      end else if (v.tens != 4'd0) begin
         r.ones = MAX_ONES;
         r.tens = v.tens - 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/segment7.sv
// -----------------------------------------------------------------------------
// segment7
// BCD to seven-segment decoder, active-low segments ordered {g,f,e,d,c,b,a}.
// Codes above 9 blank the display.
//   i_bcd : BCD digit
//   o_seg : segment pattern (0 = segment lit)
// -----------------------------------------------------------------------------
module segment7 (
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = 7'b1111111;
      case (i_bcd)
         4'd0: o_seg = 7'b1000000;
         4'd1: o_seg = 7'b1111001;
         4'd2: o_seg = 7'b0100100;
         4'd3: o_seg = 7'b0110000;
         4'd4: o_seg = 7'b0011001;
         4'd5: o_seg = 7'b0010010;
         4'd6: o_seg = 7'b0000010;
         4'd7: o_seg = 7'b1111000;
         4'd8: o_seg = 7'b0000000;
         4'd9: o_seg = 7'b0010000;
         default: o_seg = 7'b1111111;
      endcase
   end

endmodule

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Prescaler producing a one-cycle tick every CLK_HZ/TICK_HZ enabled cycles.
// The counter runs 0..DIV-1 while en is high and holds while en is low.
//   clk_50 : system clock
//   rst    : synchronous active-high reset (counter to 0)
//   en     : advance the counter
//   clr    : force the counter to 0 (restart a full period)
//   tick   : high in the enabled cycle where the counter is at its maximum
// CLK_HZ/TICK_HZ must be an integer >= 2 so the counter is at least 1 bit.
// -----------------------------------------------------------------------------
module tick_gen #(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 1
) (
   input  logic clk_50,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int W   = $clog2(DIV);
   localparam logic [W-1:0] CNT_MAX = W'(DIV - 1);

   logic [W-1:0] r_count;
   logic         w_at_max;

   assign w_at_max = (r_count == CNT_MAX);
   assign tick     = en && w_at_max;

   always_ff @(posedge clk_50) begin
      if (rst || clr) begin
         r_count <= '0;
      end else if (en) begin
         r_count <= w_at_max ? '0 : r_count + 1'b1;
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
// Two-digit BCD seconds countdown (00-59) with load/start/pause control and
// seven-segment outputs.
//   clk_50       : system clock (rising edge)
//   rst          : synchronous active-high reset
//   load         : capture preset (clamped to 59) into the digits
//   start        : begin / resume the countdown
//   pause        : freeze the countdown
//   preset_tens  : BCD tens digit of the preset
//   preset_ones  : BCD ones digit of the preset
//   OUT10        : segment7 pattern of the tens digit
//   OUT1         : segment7 pattern of the ones digit
//   running      : high while in RUN
//   done         : high while in DONE
//   o_dbg_state  : current FSM state (state_t encoding)
// Same-cycle priority: rst > load > pause > start.
// Valid/ready: strobes are level-sampled every rising edge; there is no
// back-pressure, so a strobe held high simply re-applies each cycle.
// -----------------------------------------------------------------------------
module countdown_timer
   import timer_pkg::*;
#(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 1
) (
   input  logic       clk_50,
   input  logic       rst,
   input  logic       load,
   input  logic       start,
   input  logic       pause,
   input  logic [3:0] preset_tens,
   input  logic [3:0] preset_ones,
   output logic [6:0] OUT10,
   output logic [6:0] OUT1,
   output logic       running,
   output logic       done,
   output logic [1:0] o_dbg_state
);

   state_t r_state;
   state_t w_next_state;
   bcd2_t  r_digits;
   bcd2_t  w_next_digits;
   bcd2_t  w_preset;
   bcd2_t  w_dec;
   logic   w_tick;
   logic   w_prescale_en;
   logic   w_prescale_clr;

   assign w_preset.tens = clamp_digit(preset_tens, MAX_TENS);
   assign w_preset.ones = clamp_digit(preset_ones, MAX_ONES);
   assign w_dec         = bcd_dec(r_digits);

   // The prescaler only advances in RUN, so it holds in PAUSED; every
   // transition into RUN clears it so a fresh full tick period starts.
   assign w_prescale_en = (r_state == ST_RUN);

   tick_gen #(
      .CLK_HZ  (CLK_HZ),
      .TICK_HZ (TICK_HZ)
   ) u_tick_gen (
      .clk_50 (clk_50),
      .rst    (rst),
      .en     (w_prescale_en),
      .clr    (w_prescale_clr),
      .tick   (w_tick)
   );

   // State and digit registers
   always_ff @(posedge clk_50) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_digits <= '0;
      end else begin
         r_state  <= w_next_state;
         r_digits <= w_next_digits;
      end
   end

   // Next-state and digit update
   always_comb begin
      w_next_state   = r_state;
      w_next_digits  = r_digits;
      w_prescale_clr = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (load) begin
               w_next_digits = w_preset;
            end else if (start) begin
               if (bcd_is_zero(r_digits)) begin
                  w_next_state = ST_DONE;
               end else begin
                  w_next_state   = ST_RUN;
                  w_prescale_clr = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (load) begin
               // load aborts the countdown
               w_next_digits = w_preset;
               w_next_state  = ST_IDLE;
            end else if (pause) begin
               // pause wins over a coincident tick: the count freezes as-is
               w_next_state = ST_PAUSED;
            end else if (bcd_is_zero(r_digits)) begin
               w_next_state = ST_DONE;
            end else if (w_tick) begin
               w_next_digits = w_dec;
               // DONE is entered on the same edge that writes 00
               if (bcd_is_zero(w_dec)) begin
                  w_next_state = ST_DONE;
               end
            end
         end
         ST_PAUSED: begin
            if (load) begin
               w_next_digits = w_preset;
               w_next_state  = ST_IDLE;
            end else if (!pause && start) begin
               w_next_state   = ST_RUN;
               w_prescale_clr = 1'b1;
            end
         end
         ST_DONE: begin
            if (load) begin
               w_next_digits = w_preset;
               w_next_state  = ST_IDLE;
            end
         end
         default: begin
            w_next_state  = ST_IDLE;
            w_next_digits = '0;
         end
      endcase
   end

   assign running     = (r_state == ST_RUN);
   assign done        = (r_state == ST_DONE);
   assign o_dbg_state = r_state;

   segment7 u_seg_tens (
      .i_bcd (r_digits.tens),
      .o_seg (OUT10)
   );

   segment7 u_seg_ones (
      .i_bcd (r_digits.ones),
      .o_seg (OUT1)
   );

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
// Directed bench for countdown_timer with CLK_HZ=10, TICK_HZ=1 (10-cycle tick).
// Single-cycle control behaviour comes from a vector table; the countdown,
// pause/resume and mid-count reset are hand-written cycle sequences.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RUN    = 2'd1;
   localparam logic [1:0] S_PAUSED = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   // clock / reset block
   logic       clk_50 = 1'b0;
   logic       rst = 1'b0;
   logic       load = 1'b0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic [3:0] preset_tens = 4'd0;
   logic [3:0] preset_ones = 4'd0;
   logic [6:0] OUT10;
   logic [6:0] OUT1;
   logic       running;
   logic       done;
   logic [1:0] o_dbg_state;

   always #5 clk_50 = ~clk_50;

   countdown_timer #(
      .CLK_HZ  (10),
      .TICK_HZ (1)
   ) dut (
      .clk_50      (clk_50),
      .rst         (rst),
      .load        (load),
      .start       (start),
      .pause       (pause),
      .preset_tens (preset_tens),
      .preset_ones (preset_ones),
      .OUT10       (OUT10),
      .OUT1        (OUT1),
      .running     (running),
      .done        (done),
      .o_dbg_state (o_dbg_state)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference segment patterns, active-low {g,f,e,d,c,b,a}
   function automatic logic [6:0] seg_ref(input int d);
      case (d)
         0: return 7'h40;
         1: return 7'h79;
         2: return 7'h24;
         3: return 7'h30;
         4: return 7'h19;
         5: return 7'h12;
         6: return 7'h02;
         7: return 7'h78;
         8: return 7'h00;
         9: return 7'h10;
         default: return 7'h7f;
      endcase
   endfunction

   // Expected observation {OUT10, OUT1, running, done, state} for a value 0..59
   function automatic logic [17:0] exp_obs(input int val, input logic r,
                                           input logic d, input logic [1:0] s);
      return {seg_ref(val / 10), seg_ref(val % 10), r, d, s};
   endfunction

   // scoreboard: expected queue filled by each step, popped on compare
   logic [17:0] exp_q[$];

   task automatic check(input string name);
      logic [17:0] got;
      logic [17:0] exp;
      got = {OUT10, OUT1, running, done, o_dbg_state};
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: scoreboard empty, got %h", name, got);
      end else begin
         exp = exp_q.pop_front();
         n_checks++;
         if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h (seg10=%h seg1=%h run=%b done=%b st=%0d) expected %h",
                     name, got, got[17:11], got[10:4], got[3], got[2], got[1:0], exp);
         end
      end
   endtask

   // driver: apply inputs, clock once, sample 1 time unit after the edge
   task automatic drive(input logic r, input logic l, input logic s,
                        input logic p, input logic [3:0] pt, input logic [3:0] po);
      rst         = r;
      load        = l;
      start       = s;
      pause       = p;
      preset_tens = pt;
      preset_ones = po;
      @(posedge clk_50);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
   endtask

   typedef struct packed {
      logic       rst;
      logic       load;
      logic       start;
      logic       pause;
      logic [3:0] pt;
      logic [3:0] po;
      logic [6:0] val;
      logic       er;
      logic       ed;
      logic [1:0] es;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic l, input logic s,
                               input logic p, input int pt, input int po,
                               input int val, input logic er, input logic ed,
                               input logic [1:0] es);
      vec_t v;
      v.rst = r;  v.load = l;  v.start = s;  v.pause = p;
      v.pt = 4'(pt);  v.po = 4'(po);  v.val = 7'(val);
      v.er = er;  v.ed = ed;  v.es = es;
      return v;
   endfunction

   localparam int NV = 17;
   vec_t vecs[NV];

   initial begin
      //             rst  load start pause pt  po  val run done state
      vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 0,  0,  0, 1'b0, 1'b0, S_IDLE);   // reset
      vecs[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 2,  5, 25, 1'b0, 1'b0, S_IDLE);   // load 25
      vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 0,  0, 25, 1'b0, 1'b0, S_IDLE);   // hold
      vecs[3]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 7, 12, 59, 1'b0, 1'b0, S_IDLE);   // clamp both
      vecs[4]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 0,  0,  0, 1'b0, 1'b0, S_IDLE);   // load 00
      vecs[5]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 0,  0,  0, 1'b0, 1'b1, S_DONE);   // zero start
      vecs[6]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 0,  0,  0, 1'b0, 1'b1, S_DONE);   // start ignored
      vecs[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 3,  4, 34, 1'b0, 1'b0, S_IDLE);   // load from DONE
      vecs[8]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 0,  0, 34, 1'b1, 1'b0, S_RUN);    // start
      vecs[9]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1,  2, 12, 1'b0, 1'b0, S_IDLE);   // load+start in RUN
      vecs[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 0,  0, 12, 1'b1, 1'b0, S_RUN);    // start
      vecs[11] = mk(1'b0, 1'b0, 1'b1, 1'b1, 0,  0, 12, 1'b0, 1'b0, S_PAUSED); // pause+start in RUN
      vecs[12] = mk(1'b0, 1'b0, 1'b1, 1'b0, 0,  0, 12, 1'b1, 1'b0, S_RUN);    // resume
      vecs[13] = mk(1'b0, 1'b1, 1'b0, 1'b1, 4,  4, 44, 1'b0, 1'b0, S_IDLE);   // load beats pause
      vecs[14] = mk(1'b0, 1'b1, 1'b0, 1'b0, 6,  9, 59, 1'b0, 1'b0, S_IDLE);   // tens clamp
      vecs[15] = mk(1'b1, 1'b1, 1'b1, 1'b0, 2,  2,  0, 1'b0, 1'b0, S_IDLE);   // rst beats load
      vecs[16] = mk(1'b0, 1'b0, 1'b0, 1'b1, 0,  0,  0, 1'b0, 1'b0, S_IDLE);   // pause in IDLE

      repeat (2) @(posedge clk_50);
      #1;

      // table-driven single-cycle vectors
      for (int i = 0; i < NV; i++) begin
         exp_q.push_back(exp_obs(int'(vecs[i].val), vecs[i].er, vecs[i].ed, vecs[i].es));
         drive(vecs[i].rst, vecs[i].load, vecs[i].start, vecs[i].pause,
               vecs[i].pt, vecs[i].po);
         check($sformatf("vec%0d", i));
      end

      // countdown 10 -> 00 with borrow; done/running flip at cycle 100
      exp_q.push_back(exp_obs(10, 1'b0, 1'b0, S_IDLE));
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0);
      check("cd_load");
      exp_q.push_back(exp_obs(10, 1'b1, 1'b0, S_RUN));
      drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      check("cd_start");
      for (int k = 1; k <= 105; k++) begin
         if (k >= 100) exp_q.push_back(exp_obs(0, 1'b0, 1'b1, S_DONE));
         else          exp_q.push_back(exp_obs(10 - k / 10, 1'b1, 1'b0, S_RUN));
         idle();
         check($sformatf("cd_k%0d", k));
      end

      // pause at cycle 15, resume at cycle 40, next decrement at cycle 50
      exp_q.push_back(exp_obs(5, 1'b0, 1'b0, S_IDLE));
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd5);
      check("pr_load");
      exp_q.push_back(exp_obs(5, 1'b1, 1'b0, S_RUN));
      drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      check("pr_start");
      for (int k = 1; k <= 55; k++) begin
         int  v;
         logic r;
         v = (k < 10) ? 5 : ((k < 50) ? 4 : 3);
         r = (k < 15) || (k >= 40);
         exp_q.push_back(exp_obs(v, r, 1'b0, r ? S_RUN : S_PAUSED));
         drive(1'b0, 1'b0, (k == 40), (k == 15), 4'd0, 4'd0);
         check($sformatf("pr_k%0d", k));
      end

      // reset in the middle of a countdown at 33
      exp_q.push_back(exp_obs(34, 1'b0, 1'b0, S_IDLE));
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd4);
      check("mr_load");
      exp_q.push_back(exp_obs(34, 1'b1, 1'b0, S_RUN));
      drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      check("mr_start");
      for (int k = 1; k <= 12; k++) begin
         exp_q.push_back(exp_obs((k < 10) ? 34 : 33, 1'b1, 1'b0, S_RUN));
         idle();
         check($sformatf("mr_k%0d", k));
      end
      exp_q.push_back(exp_obs(0, 1'b0, 1'b0, S_IDLE));
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      check("mr_rst");
      exp_q.push_back(exp_obs(0, 1'b0, 1'b0, S_IDLE));
      idle();
      check("mr_after");

      // final report
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
